nmos_clk_gen: RTL
=================

Name: nmos_clk_gen

Overview:
- Two-phase non-overlapping clock sequencer that drives the C1/C2 phase-enable inputs of the NMOS cell library (latches, LD-style registers, shifters).
- Runs on the fast simulation clock `main_clk`. Emits PHI1/PHI2 level windows plus one-tick capture strobes that the cells sample at `posedge main_clk`.
- Adds run/stop and single-step control and a completed-cycle counter for bench and debug use.

Parameters:
- HIGH_W, 2, main_clk cycles each phase is high (>=1)
- GAP_W, 1, main_clk dead cycles between phases (>=1; guarantees non-overlap)
- CNT_W, 32, width of the completed-cycle counter

Ports:
- main_clk  in  1  fast simulation clock; all state updates on its rising edge
- rst_n  in  1  synchronous active-low reset, sampled at posedge main_clk
- run  in  1  level; 1 = free-run phase cycles
- step  in  1  one-tick pulse; while idle, requests exactly one full phase cycle
- phi1  out  1  PHI1 level window
- phi2  out  1  PHI2 level window
- C1  out  1  PHI1 capture strobe, high on the last tick of the phi1 window
- C2  out  1  PHI2 capture strobe, high on the last tick of the phi2 window
- busy  out  1  1 whenever state != IDLE
- cyc_cnt  out  CNT_W  number of completed phase cycles

Behaviour:
- State register: IDLE, PH1, GAP1, PH2, GAP2, plus a tick counter `tcnt` sized for max(HIGH_W, GAP_W).
- Outputs decode combinationally from the registered state and `tcnt` only, so they are glitch-free. Exact decode:
  - phi1 = (state==PH1)
  - phi2 = (state==PH2)
  - C1 = PH1 && tcnt==HIGH_W-1
  - C2 = PH2 && tcnt==HIGH_W-1
- Reset: when rst_n=0 at a posedge, state=IDLE, tcnt=0, step_pend=0, cyc_cnt=0. All outputs read 0 from the following cycle. Reset wins over every other input, including mid-cycle; there is no completion of a partial cycle.
- IDLE:
  - if run=1 or step=1 (step=1 sets step_pend), go to PH1 with tcnt=0.
  - otherwise stay in IDLE.
- PH1: stay HIGH_W ticks; on tcnt==HIGH_W-1 go to GAP1 with tcnt=0.
- GAP1: stay GAP_W ticks, then go to PH2.
- PH2: stay HIGH_W ticks, then go to GAP2.
- GAP2: stay GAP_W ticks. On its last tick:
  - cyc_cnt increments (wraps modulo 2^CNT_W, no saturation).
  - step_pend clears.
  - next state is PH1 if run=1, else IDLE.
- Full period = 2*(HIGH_W+GAP_W) ticks. phi1 and phi2 are never high in the same cycle. C1/C2 are exactly one tick wide per window.
- Latency: with IDLE and run rising at posedge t, phi1 is high in the cycles after edges t..t+HIGH_W-1.
- run deasserted mid-cycle: the current cycle completes through GAP2, then returns to IDLE. Cells never see a truncated phase.
- step while busy: ignored and not queued.
- step and run both high in IDLE: behaves as run. After run falls, the cycle completes and returns to IDLE.
- cyc_cnt is read-only and never decrements.

Test Plan:
- Reset then run=1 (defaults) -> phi1 high 2 ticks, gap 1, phi2 high 2, gap 1; period 6; C1 on 2nd phi1 tick only; after 60 ticks cyc_cnt=10; phi1&phi2 never both 1.
- IDLE, step pulse, run=0 -> exactly one cycle (6 ticks, one C1, one C2); busy 6 ticks; cyc_cnt 0->1; back to IDLE; phi1=phi2=0 afterward.
- run=1, drop run during PH2 -> GAP2 completes, then IDLE; cyc_cnt increments once on that cycle; no further phi1.
- rst_n=0 asserted during PH1 tick 1 -> next cycle phi1=0, C1 never fires, busy=0, cyc_cnt=0; release with run=1 -> clean restart at PH1 tcnt=0.
- step pulse while busy -> no extra cycle after run drops; cyc_cnt counts only run cycles.
- CNT_W=4, run for 17 cycles -> cyc_cnt goes 15 -> 0 -> 1. Also with HIGH_W=1, GAP_W=1: period 4, C1 coincident with the single phi1 tick.

Source files
------------

// File: rtl/nmos_clk_gen.sv
// -----------------------------------------------------------------------------
// nmos_clk_gen
//
// Two-phase non-overlapping clock sequencer for the NMOS cell library. The
// sequence is PH1, GAP1, PH2, GAP2. It advances one tick per rising edge of
// main_clk. The outputs are level windows (phi1/phi2) and one-tick capture
// strobes (C1/C2). The cells sample these strobes at posedge main_clk.
//
// Parameters:
//   HIGH_W  main_clk cycles each phase is high (>=1)
//   GAP_W   dead cycles between phases (>=1)
//   CNT_W   width of the completed-cycle counter
//
// Ports:
//   main_clk  in   fast clock; all state updates on its rising edge
//   rst_n     in   synchronous active-low reset
//   run       in   level; 1 = free-run phase cycles
//   step      in   one-tick pulse; while idle, runs exactly one phase cycle
//   phi1      out  PHI1 level window
//   phi2      out  PHI2 level window
//   C1        out  PHI1 capture strobe, last tick of the phi1 window
//   C2        out  PHI2 capture strobe, last tick of the phi2 window
//   busy      out  1 whenever a phase cycle is in progress
//   cyc_cnt   out  number of completed phase cycles (wraps)
// -----------------------------------------------------------------------------
module nmos_clk_gen #(
  parameter int HIGH_W = 2,
  parameter int GAP_W  = 1,
  parameter int CNT_W  = 32
) (
  input  logic             main_clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  output logic             phi1,
  output logic             phi2,
  output logic             C1,
  output logic             C2,
  output logic             busy,
  output logic [CNT_W-1:0] cyc_cnt
);

  // The tick counter must hold the longest dwell, whether phase or gap.
  localparam int MAX_T  = (HIGH_W > GAP_W) ? HIGH_W : GAP_W;
  localparam int TCNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TCNT_W-1:0] HIGH_LAST = TCNT_W'(HIGH_W - 1);
  localparam logic [TCNT_W-1:0] GAP_LAST  = TCNT_W'(GAP_W - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PH1  = 3'd1;
  localparam logic [2:0] S_GAP1 = 3'd2;
  localparam logic [2:0] S_PH2  = 3'd3;
  localparam logic [2:0] S_GAP2 = 3'd4;

  logic [2:0]        state_q,     state_d;
  logic [TCNT_W-1:0] tcnt_q,      tcnt_d;
  logic              step_pend_q, step_pend_d;
  logic [CNT_W-1:0]  cyc_cnt_q,   cyc_cnt_d;

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    step_pend_d = step_pend_q;
    cyc_cnt_d   = cyc_cnt_q;

    case (state_q)
      S_IDLE: begin
        // run and step are only considered here. A step that arrives while
        // busy is dropped, not queued.
        if (run || step) begin
          state_d     = S_PH1;
          tcnt_d      = '0;
          step_pend_d = step;
        end
      end

      S_PH1: begin
        if (tcnt_q == HIGH_LAST) begin
          state_d = S_GAP1;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      S_GAP1: begin
        if (tcnt_q == GAP_LAST) begin
          state_d = S_PH2;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      S_PH2: begin
        if (tcnt_q == HIGH_LAST) begin
          state_d = S_GAP2;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      S_GAP2: begin
        if (tcnt_q == GAP_LAST) begin
          // The cycle is complete. Only run decides whether another cycle
          // starts, so a finished step returns to idle.
          cyc_cnt_d   = cyc_cnt_q + CNT_W'(1);
          step_pend_d = 1'b0;
          tcnt_d      = '0;
          state_d     = run ? S_PH1 : S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        tcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge main_clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      step_pend_q <= 1'b0;
      cyc_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      step_pend_q <= step_pend_d;
      cyc_cnt_q   <= cyc_cnt_d;
    end
  end

  // Decode only from registered state, so the outputs cannot glitch.
  assign phi1    = (state_q == S_PH1);
  assign phi2    = (state_q == S_PH2);
  assign C1      = (state_q == S_PH1) && (tcnt_q == HIGH_LAST);
  assign C2      = (state_q == S_PH2) && (tcnt_q == HIGH_LAST);
  assign busy    = (state_q != S_IDLE);
  assign cyc_cnt = cyc_cnt_q;

endmodule
